peak_hold_multi: RTL and testbench

Multi-channel windowed peak detector for the DDC output path. Each of NCH signed channels is reduced to a magnitude, and a running per-channel maximum is held over a measurement window framed by rising edges of the `ms_in` strobe. At each window close the block reports the largest magnitude across all channels, which channel produced it, and the in-window sample index at which it occurred. It replaces the single-channel peak holder feeding the power-monitor registers.

---
 rtl/peak_hold_pkg.sv | 40 ++++
 rtl/peak_tree.sv | 51 +++++
 rtl/peak_hold_multi.sv | 116 +++++++++++
 tb/tb_peak_hold_multi.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/peak_hold_pkg.sv
// Shared types and helpers for the multi-channel windowed peak detector.
// Magnitude rule, width helpers and the default tree node record.
package peak_hold_pkg;

  localparam int PH_MAX_W = 64;
  localparam int PH_W     = 32;
  localparam int PH_NCH   = 4;
  localparam int PH_PW    = 24;

  function automatic int chw_f(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

  function automatic int lvl_f(input int nch);
    return (nch > 1) ? $clog2(nch) : 0;
  endfunction

  localparam int PH_CHW = chw_f(PH_NCH);

  typedef struct packed {
    logic [PH_W-1:0]   mag;
    logic [PH_CHW-1:0] ch;
    logic [PH_PW-1:0]  pos;
  } ph_node_t;

  // x arrives sign-extended from w bits; the result always fits in w-1 bits.
  // mode 1: two's-complement abs with the most negative value clamped.
  // mode 0: legacy ones-complement fold, so -1 becomes 0.
  function automatic logic [PH_MAX_W-1:0] mag_f(input logic [PH_MAX_W-1:0] x,
                                                 input logic mode, input int w);
    logic [PH_MAX_W-1:0] lim, r;
    lim = (PH_MAX_W'(1) << (w - 1)) - PH_MAX_W'(1);
    if (!x[PH_MAX_W-1]) r = x;
    else if (mode)      r = ~x + PH_MAX_W'(1);
    else                r = ~x;
    if (r > lim) r = lim;
    return r;
  endfunction

endpackage

// File: rtl/peak_tree.sv
// Registered compare-select reduction of NCH {mag, ch, pos} records.
// One register per tree level; ties keep the lower-index input.
module peak_tree import peak_hold_pkg::*; #(
  parameter int  NCH    = PH_NCH,
  parameter type node_t = ph_node_t
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  node_t [NCH-1:0] in_node,
  output logic            out_valid,
  output node_t           out_node
);
  localparam int L = lvl_f(NCH);
  localparam int P = 1 << L;

  if (L == 0) begin : g_pass
    assign out_valid = in_valid;
    assign out_node  = in_node[0];
  end else begin : g_tree
    // Heap layout: leaves at P..2P-1 (zero-padded), internal nodes 1..P-1.
    node_t [2*P-1:2] heap;
    node_t [P-1:1]   node_d, node_q;
    logic  [L-1:0]   vld_q;
    logic  [L:0]     vld_pipe;

    assign vld_pipe = {vld_q, in_valid};

    always_comb begin
      heap = '0;
      for (int i = 0; i < NCH; i++) heap[P+i] = in_node[i];
      for (int n = 2; n < P; n++)   heap[n]   = node_q[n];
      for (int n = 1; n < P; n++)
        node_d[n] = (heap[2*n+1].mag > heap[2*n].mag) ? heap[2*n+1] : heap[2*n];
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        node_q <= '0;
        vld_q  <= '0;
      end else begin
        node_q <= node_d;
        vld_q  <= vld_pipe[L-1:0];
      end
    end

    assign out_valid = vld_pipe[L];
    assign out_node  = node_q[1];
  end

endmodule

// File: rtl/peak_hold_multi.sv
// Multi-channel windowed peak detector: per-channel magnitude and running
// max, frozen on each ms_in rise and reduced to one {mag, ch, pos} report.
module peak_hold_multi import peak_hold_pkg::*; #(
  parameter int  W    = 32,
  parameter int  NCH  = 4,
  parameter int  PW   = 24,
  parameter int  MODE = 1,
  localparam int CHW  = chw_f(NCH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ms_in,
  input  logic [NCH*W-1:0] din,
  input  logic             din_valid,
  output logic [W-1:0]     max_out,
  output logic [CHW-1:0]   max_ch,
  output logic [PW-1:0]    max_pos,
  output logic             max_valid
);
  typedef struct packed {
    logic [W-1:0]   mag;
    logic [CHW-1:0] ch;
    logic [PW-1:0]  pos;
  } node_t;

  logic [NCH-1:0][W-1:0]  mag_d, mag_q;
  logic                   mag_v_q;
  logic                   ms_r1_q, ms_r2_q, close;
  logic [PW-1:0]          cnt_d, cnt_q;
  logic [NCH-1:0][W-1:0]  inner_d, inner_q;
  logic [NCH-1:0][PW-1:0] ipos_d, ipos_q;
  logic [NCH-1:0]         win;
  node_t [NCH-1:0]        hold_d, hold_q;
  logic                   hold_v_q;
  logic                   tree_v;
  node_t                  tree_node;
  node_t                  out_d, out_q;
  logic                   max_valid_q;

  assign close = ms_r1_q & ~ms_r2_q;

  always_comb begin
    for (int c = 0; c < NCH; c++)
      mag_d[c] = W'(mag_f(PH_MAX_W'($signed(din[c*W +: W])), MODE != 0, W));
  end

  // The sample sitting in stage M during close still belongs to the old window.
  always_comb begin
    cnt_d = cnt_q;
    if (close)                       cnt_d = mag_v_q ? PW'(1) : '0;
    else if (mag_v_q && cnt_q != '1) cnt_d = cnt_q + PW'(1);

    win     = '0;
    inner_d = inner_q;
    ipos_d  = ipos_q;
    hold_d  = hold_q;
    for (int c = 0; c < NCH; c++) begin
      win[c] = mag_v_q && (mag_q[c] > inner_q[c]);
      if (close) begin
        hold_d[c].mag = win[c] ? mag_q[c] : inner_q[c];
        hold_d[c].pos = win[c] ? cnt_q    : ipos_q[c];
        hold_d[c].ch  = CHW'(c);
        inner_d[c]    = '0;
        ipos_d[c]     = '0;
      end else if (win[c]) begin
        inner_d[c] = mag_q[c];
        ipos_d[c]  = cnt_q;
      end
    end
  end

  assign out_d = tree_v ? tree_node : out_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      mag_q       <= '0;
      mag_v_q     <= 1'b0;
      ms_r1_q     <= 1'b0;
      ms_r2_q     <= 1'b0;
      cnt_q       <= '0;
      inner_q     <= '0;
      ipos_q      <= '0;
      hold_q      <= '0;
      hold_v_q    <= 1'b0;
      out_q       <= '0;
      max_valid_q <= 1'b0;
    end else begin
      mag_q       <= mag_d;
      mag_v_q     <= din_valid;
      ms_r1_q     <= ms_in;
      ms_r2_q     <= ms_r1_q;
      cnt_q       <= cnt_d;
      inner_q     <= inner_d;
      ipos_q      <= ipos_d;
      hold_q      <= hold_d;
      hold_v_q    <= close;
      out_q       <= out_d;
      max_valid_q <= tree_v;
    end
  end

  peak_tree #(.NCH(NCH), .node_t(node_t)) u_tree (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (hold_v_q),
    .in_node   (hold_q),
    .out_valid (tree_v),
    .out_node  (tree_node)
  );

  assign max_out   = out_q.mag;
  assign max_ch    = out_q.ch;
  assign max_pos   = out_q.pos;
  assign max_valid = max_valid_q;

endmodule

// File: tb/tb_peak_hold_multi.sv
// Scoreboard bench for peak_hold_multi: a MODE 1 and a MODE 0 instance share
// stimulus; expected window reports are queued and popped on max_valid.
module tb_peak_hold_multi;
  localparam int W = 32, NCH = 4, PW = 24;

  logic clk = 1'b0, rst = 1'b1, ms_in = 1'b0, din_valid = 1'b0;
  logic [NCH*W-1:0] din = '0;
  logic [W-1:0]  mo1, mo0;
  logic [1:0]    mc1, mc0;
  logic [PW-1:0] mp1, mp0;
  logic          mv1, mv0;

  typedef struct {
    logic [W-1:0]  mag;
    logic [1:0]    ch;
    logic [PW-1:0] pos;
    int            cyc;
  } exp_t;

  exp_t q1[$], q0[$];
  int n_vec = 0, n_bad = 0, cyc = 0;

  peak_hold_multi #(.W(W), .NCH(NCH), .PW(PW), .MODE(1)) dut1 (
    .clk(clk), .rst(rst), .ms_in(ms_in), .din(din), .din_valid(din_valid),
    .max_out(mo1), .max_ch(mc1), .max_pos(mp1), .max_valid(mv1));

  peak_hold_multi #(.W(W), .NCH(NCH), .PW(PW), .MODE(0)) dut0 (
    .clk(clk), .rst(rst), .ms_in(ms_in), .din(din), .din_valid(din_valid),
    .max_out(mo0), .max_ch(mc0), .max_pos(mp0), .max_valid(mv0));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitors: pop one expected window per max_valid pulse.
  always @(negedge clk) begin
    exp_t e;
    if (mv1 === 1'b1) begin
      chk("d1 pulse has pending window", 64'(q1.size() > 0), 64'd1);
      if (q1.size() > 0) begin
        e = q1.pop_front();
        chk("d1 max_out", 64'(mo1), 64'(e.mag));
        chk("d1 max_ch",  64'(mc1), 64'(e.ch));
        chk("d1 max_pos", 64'(mp1), 64'(e.pos));
        chk("d1 latency", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (mv0 === 1'b1) begin
      chk("d0 pulse has pending window", 64'(q0.size() > 0), 64'd1);
      if (q0.size() > 0) begin
        e = q0.pop_front();
        chk("d0 max_out", 64'(mo0), 64'(e.mag));
        chk("d0 max_ch",  64'(mc0), 64'(e.ch));
        chk("d0 max_pos", 64'(mp0), 64'(e.pos));
        chk("d0 latency", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic drv(input logic signed [W-1:0] a0, input logic signed [W-1:0] a1,
                     input logic signed [W-1:0] a2, input logic signed [W-1:0] a3,
                     input logic v, input logic ms);
    din = {a3, a2, a1, a0};
    din_valid = v;
    ms_in = ms;
    @(posedge clk);
    #1;
  endtask

  // Report lands 5 edges after the cycle in which ms_in is raised.
  task automatic push(input logic [W-1:0] m1, input logic [1:0] c1, input logic [PW-1:0] p1,
                      input logic [W-1:0] m0, input logic [1:0] c0, input logic [PW-1:0] p0);
    q1.push_back('{m1, c1, p1, cyc + 5});
    q0.push_back('{m0, c0, p0, cyc + 5});
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " max_out"},   64'(mo1), 64'd0);
    chk({tag, " max_ch"},    64'(mc1), 64'd0);
    chk({tag, " max_pos"},   64'(mp1), 64'd0);
    chk({tag, " max_valid"}, 64'(mv1), 64'd0);
    chk({tag, " d0 max_out"}, 64'(mo0), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) drv(0, 0, 0, 0, 0, 0);
    chk_zero("reset");
    rst = 1'b0;

    // Channel 2 peaks at -1000 on sample 7; others stay below 500.
    for (int i = 0; i < 8; i++)
      drv(100 + 10*i, -(200 + i), (i == 7) ? -1000 : 50, (i == 3) ? 499 : 10, 1, 0);
    push(1000, 2, 7, 999, 2, 7);
    drv(0, 0, 0, 0, 0, 1);

    // Most negative input and -1 under both magnitude rules.
    drv(32'h8000_0000, 0, 0, 0, 1, 0);
    push(32'h7FFF_FFFF, 0, 0, 32'h7FFF_FFFF, 0, 0);
    drv(0, 0, 0, 0, 0, 1);
    drv(-1, 0, 0, 0, 1, 0);
    push(1, 0, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 1);

    // Cross-channel tie goes to the lower channel.
    for (int i = 0; i < 6; i++)
      drv(i, (i == 4) ? 300 : 20, 0, (i == 4) ? 300 : 30, 1, 0);
    push(300, 1, 4, 300, 1, 4);
    drv(0, 0, 0, 0, 0, 1);

    // Repeat within a channel keeps the first position.
    for (int i = 0; i < 10; i++)
      drv((i == 2 || i == 9) ? 300 : 0, 100, 0, (i == 5) ? -300 : 0, 1, 0);
    push(300, 0, 2, 300, 0, 2);
    drv(0, 0, 0, 0, 0, 1);

    // Peak in stage M on the close cycle; next window starts at count 1.
    for (int i = 0; i < 3; i++) drv(0, 10*(i + 1), 0, 0, 1, 0);
    push(5000, 3, 3, 5000, 3, 3);
    drv(0, 0, 0, 5000, 1, 1);
    drv(77, 0, 0, 0, 1, 0);
    push(77, 0, 1, 77, 0, 1);
    drv(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) drv(0, 0, 0, 0, 0, 0);
    chk("hold max_out", 64'(mo1), 64'd77);
    chk("hold max_pos", 64'(mp1), 64'd1);

    // Reset 2 cycles after the rise: the in-flight window must vanish.
    drv(0, 0, 900, 0, 1, 0);
    drv(0, 0, 0, 0, 0, 1);
    drv(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    drv(0, 0, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) drv(0, 0, 0, 0, 0, 0);
    chk_zero("mid-window reset");
    drv(0, -42, 0, 0, 1, 0);
    push(42, 1, 0, 41, 1, 0);
    drv(0, 0, 0, 0, 0, 1);

    // Back-to-back empty windows at the minimum close spacing.
    drv(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      push(0, 0, 0, 0, 0, 0);
      drv(0, 0, 0, 0, 0, 1);
      drv(0, 0, 0, 0, 0, 0);
    end

    for (int i = 0; i < 40 && (q1.size() > 0 || q0.size() > 0); i++) drv(0, 0, 0, 0, 0, 0);
    chk("d1 windows reported", 64'(q1.size()), 64'd0);
    chk("d0 windows reported", 64'(q0.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
